clock_divider: RTL and testbench



---
 rtl/clock_divider_pkg.sv | 25 ++
 rtl/clock_divider.sv | 53 +++++
 tb/tb_clock_divider.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/clock_divider_pkg.sv
// Shared constants and elaboration helpers for the clock_divider block.
// Holds the counter width and the ratio-to-half-period arithmetic.
package clock_divider_pkg;

    localparam int COUNTER_WIDTH = 16;
    localparam int MIN_RATIO     = 2;
    localparam int MAX_RATIO     = 131072;

    // Registered divider state: half-period count plus the phase flop that drives clk_out.
    typedef struct packed {
        logic [COUNTER_WIDTH-1:0] count;
        logic                     phase;
    } div_state_t;

    localparam div_state_t DIV_STATE_IDLE = '{count: '0, phase: 1'b0};

    function automatic int half_of(input int ratio);
        return ratio / 2;
    endfunction

    function automatic bit ratio_is_legal(input int ratio);
        return (ratio >= MIN_RATIO) && (ratio <= MAX_RATIO) && ((ratio % 2) == 0);
    endfunction

endpackage

// File: rtl/clock_divider.sv
// Even-ratio clock divider producing a 50% duty clk_out with selectable idle level.
// clk_out comes straight from a single flop XOR a quasi-static polarity, so it cannot glitch.
module clock_divider
    import clock_divider_pkg::*;
#(
    parameter int CLOCK_RATIO = 4
) (
    input  logic                     clk_in,
    input  logic                     sync_rst,
    input  logic                     clk_en,
    input  logic                     cpol,
    output logic [COUNTER_WIDTH-1:0] counter_out,
    output logic                     clk_out
);

    localparam int                       HALF       = half_of(CLOCK_RATIO);
    localparam logic [COUNTER_WIDTH-1:0] COUNT_LAST = COUNTER_WIDTH'(HALF - 1);

    if (!ratio_is_legal(CLOCK_RATIO)) begin : g_bad_ratio
        $fatal(1, "clock_divider: CLOCK_RATIO=%0d must be even and within 2..131072",
               CLOCK_RATIO);
    end

    div_state_t state_q;
    div_state_t state_d;

    // NOTE: every field gets its hold value first, so no path through the block
    // leaves a signal unassigned and no latch can be inferred.
    always_comb begin
        state_d = state_q;
        if (!clk_en) begin
            state_d = DIV_STATE_IDLE;
        end else if (state_q.count == COUNT_LAST) begin
            state_d.count = '0;
            state_d.phase = ~state_q.phase;
        end else begin
            state_d.count = state_q.count + COUNTER_WIDTH'(1);
        end
    end

    // NOTE: non-blocking assignment keeps every flop updating from pre-edge values.
    always_ff @(posedge clk_in) begin
        if (sync_rst) begin
            state_q <= DIV_STATE_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign counter_out = state_q.count;
    assign clk_out     = state_q.phase ^ cpol;

endmodule

// File: tb/tb_clock_divider.sv
// Self-checking bench for clock_divider at ratios 2, 4 and 10 sharing one stimulus stream.
// Reference: n enabled edges since the last reset/disable give count = n % HALF, phase = (n / HALF) % 2.
module tb_clock_divider;

    logic        clk_in;
    logic        sync_rst;
    logic        clk_en;
    logic        cpol;
    logic [15:0] cnt2, cnt4, cnt10;
    logic        out2, out4, out10;

    int vectors;
    int miscompares;
    int n_enabled;

    clock_divider #(.CLOCK_RATIO(2)) dut2 (
        .clk_in(clk_in), .sync_rst(sync_rst), .clk_en(clk_en), .cpol(cpol),
        .counter_out(cnt2), .clk_out(out2)
    );

    clock_divider #(.CLOCK_RATIO(4)) dut4 (
        .clk_in(clk_in), .sync_rst(sync_rst), .clk_en(clk_en), .cpol(cpol),
        .counter_out(cnt4), .clk_out(out4)
    );

    clock_divider #(.CLOCK_RATIO(10)) dut10 (
        .clk_in(clk_in), .sync_rst(sync_rst), .clk_en(clk_en), .cpol(cpol),
        .counter_out(cnt10), .clk_out(out10)
    );

    initial begin
        clk_in = 1'b0;
        forever #10 clk_in = ~clk_in;
    end

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] exp_count(input int half);
        return 16'(n_enabled % half);
    endfunction

    function automatic logic [15:0] exp_clk(input int half);
        return {15'b0, ((n_enabled / half) % 2 == 1) ^ cpol};
    endfunction

    task automatic check_model(input string tag);
        check({tag, "/r2_cnt"},  cnt2,           exp_count(1));
        check({tag, "/r2_clk"},  {15'b0, out2},  exp_clk(1));
        check({tag, "/r4_cnt"},  cnt4,           exp_count(2));
        check({tag, "/r4_clk"},  {15'b0, out4},  exp_clk(2));
        check({tag, "/r10_cnt"}, cnt10,          exp_count(5));
        check({tag, "/r10_clk"}, {15'b0, out10}, exp_clk(5));
    endtask

    // Apply inputs, take one rising edge, advance the reference, sample 1 ns later.
    task automatic step(input logic rst, input logic en, input string tag);
        sync_rst = rst;
        clk_en   = en;
        @(posedge clk_in);
        if (rst || !en) n_enabled = 0;
        else            n_enabled++;
        #1;
        check_model(tag);
    endtask

    // Polarity may only move while idle; clk_out must follow it immediately.
    task automatic flip_cpol_idle(input string tag);
        step(1'b0, 1'b0, {tag, "/idle"});
        cpol = ~cpol;
        #1;
        check({tag, "/r4_follow"},  {15'b0, out4},  {15'b0, cpol});
        check({tag, "/r10_follow"}, {15'b0, out10}, {15'b0, cpol});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        n_enabled   = 0;
        sync_rst    = 1'b1;
        clk_en      = 1'b1;
        cpol        = 1'b1;
        #1;

        // Reset with cpol=1, then free-run: ratio 4 counts 1,0,1,0 and toggles every 2 edges.
        step(1'b1, 1'b1, "rst_cpol1");
        check("rst_r4_cnt", cnt4, 16'd0);
        check("rst_r4_clk", {15'b0, out4}, 16'd1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, "run_cpol1");

        // Drop enable mid-period while clk_out is away from idle.
        step(1'b1, 1'b1, "rst_b");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, "pre_drop");
        check("mid_r4_cnt", cnt4, 16'd1);
        check("mid_r4_clk", {15'b0, out4}, 16'd0);
        step(1'b0, 1'b0, "drop_en");
        check("drop_r4_cnt", cnt4, 16'd0);
        check("drop_r4_clk", {15'b0, out4}, 16'd1);
        step(1'b0, 1'b1, "reen1");
        check("reen1_r4_clk", {15'b0, out4}, 16'd1);
        step(1'b0, 1'b1, "reen2");
        check("reen2_r4_clk", {15'b0, out4}, 16'd0);

        // Reset with enable held high mid-period aborts the period.
        step(1'b0, 1'b1, "pre_rst");
        step(1'b1, 1'b1, "rst_mid");
        check("rstmid_r4_cnt", cnt4, 16'd0);
        check("rstmid_r4_clk", {15'b0, out4}, 16'd1);
        step(1'b0, 1'b1, "post_rst");
        check("postrst_r4_clk", {15'b0, out4}, 16'd1);

        // cpol=0: idles low, first rising clk_out two edges after reset release.
        flip_cpol_idle("to_cpol0");
        step(1'b1, 1'b1, "rst_cpol0");
        check("rst0_r4_clk", {15'b0, out4}, 16'd0);
        step(1'b0, 1'b1, "c0_e1");
        check("c0e1_r4_clk", {15'b0, out4}, 16'd0);
        step(1'b0, 1'b1, "c0_e2");
        check("c0e2_r4_clk", {15'b0, out4}, 16'd1);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, "run_cpol0");

        // Randomised mix of enable drops, resets and idle polarity changes.
        for (int i = 0; i < 400; i++) begin
            int unsigned r;
            r = $urandom_range(0, 99);
            if (r < 3)       flip_cpol_idle("rnd_cpol");
            else if (r < 7)  step(1'b1, 1'($urandom_range(0, 1)), "rnd_rst");
            else if (r < 15) step(1'b0, 1'b0, "rnd_idle");
            else             step(1'b0, 1'b1, "rnd_run");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
